// File: rtl/gpu_rect_loader_if.sv
// Bundle between rect_copy_controller / rasterizer and gpu_rect_loader.
// master = controller + rasterizer side, slave = loader.
interface gpu_rect_loader_if #(
  parameter int INDEX_WIDTH = 6
);
  // Stream handshake: gpu_reset is the window valid; there is no ready, the
  // loader accepts one word every cycle after the first high cycle of a window.
  logic                   gpu_reset;
  logic [15:0]            gpu_data;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic [15:0]            rd_x;
  logic [15:0]            rd_y;
  logic [15:0]            rd_w;
  logic [15:0]            rd_h;
  logic [15:0]            rd_color;
  logic [INDEX_WIDTH:0]   rects_loaded;
  logic                   load_busy;
  logic                   load_done;
  logic                   overflow;
  logic [1:0]             fsm_state;

  modport master (
    output gpu_reset, gpu_data, rd_index,
    input  rd_x, rd_y, rd_w, rd_h, rd_color,
    input  rects_loaded, load_busy, load_done, overflow, fsm_state
  );

  modport slave (
    input  gpu_reset, gpu_data, rd_index,
    output rd_x, rd_y, rd_w, rd_h, rd_color,
    output rects_loaded, load_busy, load_done, overflow, fsm_state
  );
endinterface

// File: rtl/gpu_rect_loader.sv
// Captures the rect copy stream into a rect table with a registered read port.
// Optional GPU_RECT_LOADER_DOUBLE_BUFFER_EN: front/back banks swapped on a clean load.
module gpu_rect_loader #(
  parameter int RECT_COUNT  = 64,
  parameter int INDEX_WIDTH = 6
) (
  input logic              clk,
  input logic              reset,
  gpu_rect_loader_if.slave bus
);
  localparam int CW = INDEX_WIDTH + 1;
`ifdef GPU_RECT_LOADER_DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int ENTRIES = BANKS * RECT_COUNT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          start, capture, finish, full, wr_rec;
  logic [2:0]    field_cnt_q;
  logic [CW-1:0] rect_cnt_q, rects_loaded_q;
  logic [15:0]   stage_q [4];
  logic          overflow_q, load_busy_q, load_done_q;
  logic [79:0]   table_q [ENTRIES];
  logic [79:0]   rd_next, rd_q;
  int            wr_base, rd_base;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.gpu_reset) state_d = SKIP;
      SKIP:    state_d = bus.gpu_reset ? LOAD : IDLE;
      LOAD:    state_d = bus.gpu_reset ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first high cycle (seen in IDLE) is the controller's read-latency
  // bubble, so every high cycle seen in SKIP or LOAD carries a word.
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE:    start = bus.gpu_reset;
      SKIP,
      LOAD: begin
        capture = bus.gpu_reset;
        finish  = !bus.gpu_reset;
      end
      default: ;
    endcase
  end

  assign full   = (rect_cnt_q == CW'(RECT_COUNT));
  assign wr_rec = capture && !full && (field_cnt_q == 3'd4);

`ifdef GPU_RECT_LOADER_DOUBLE_BUFFER_EN
  logic front_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    front_q <= 1'b0;
    else if (finish && !overflow_q) front_q <= ~front_q;
  end

  always_comb begin
    wr_base = front_q ? 0 : RECT_COUNT;
    rd_base = front_q ? RECT_COUNT : 0;
  end
`else
  always_comb begin
    wr_base = 0;
    rd_base = 0;
  end
`endif

  // Load counters, staging and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_cnt_q    <= '0;
      rect_cnt_q     <= '0;
      rects_loaded_q <= '0;
      overflow_q     <= 1'b0;
      load_busy_q    <= 1'b0;
      load_done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) stage_q[i] <= '0;
    end else begin
      load_done_q <= finish;
      if (start) begin
        field_cnt_q <= '0;
        rect_cnt_q  <= '0;
        overflow_q  <= 1'b0;
        load_busy_q <= 1'b1;
      end else if (capture) begin
        if (full) begin
          overflow_q <= 1'b1;
        end else if (field_cnt_q == 3'd4) begin
          field_cnt_q <= '0;
          rect_cnt_q  <= rect_cnt_q + 1'b1;
        end else begin
          stage_q[field_cnt_q[1:0]] <= bus.gpu_data;
          field_cnt_q               <= field_cnt_q + 1'b1;
        end
      end else if (finish) begin
        load_busy_q <= 1'b0;
`ifdef GPU_RECT_LOADER_DOUBLE_BUFFER_EN
        if (!overflow_q) rects_loaded_q <= rect_cnt_q;
`else
        rects_loaded_q <= rect_cnt_q;
`endif
      end
    end
  end

  // Rect table; a partial record never reaches it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < ENTRIES; e++) table_q[e] <= '0;
    end else if (wr_rec) begin
      for (int i = 0; i < RECT_COUNT; i++)
        if (rect_cnt_q == CW'(i))
          table_q[wr_base + i] <= {bus.gpu_data, stage_q[3], stage_q[2], stage_q[1], stage_q[0]};
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < RECT_COUNT; i++)
      if (bus.rd_index == INDEX_WIDTH'(i)) rd_next = table_q[rd_base + i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_next;
  end

  assign bus.rd_x         = rd_q[15:0];
  assign bus.rd_y         = rd_q[31:16];
  assign bus.rd_w         = rd_q[47:32];
  assign bus.rd_h         = rd_q[63:48];
  assign bus.rd_color     = rd_q[79:64];
  assign bus.rects_loaded = rects_loaded_q;
  assign bus.load_busy    = load_busy_q;
  assign bus.load_done    = load_done_q;
  assign bus.overflow     = overflow_q;
  assign bus.fsm_state    = state_q;
endmodule
